// File: rtl/tiny_alu_pkg.sv
// Shared constants, types and the ALU evaluation function for tiny_alu_sched.
package tiny_alu_pkg;

  localparam logic OP_XOR = 1'b0;
  localparam logic OP_AND = 1'b1;

  localparam int ALU_W   = 4;
  localparam int ALU_LAT = 2;

  localparam logic REQ_ID_0 = 1'b0;
  localparam logic REQ_ID_1 = 1'b1;

  // Stage-1 sideband that travels alongside the operands held inside the ALU.
  typedef struct packed {
    logic valid;
    logic id;
    logic op;
  } s1_t;

  // Stage-2 sideband, aligned with the ALU result.
  typedef struct packed {
    logic valid;
    logic id;
  } s2_t;

  function automatic logic [ALU_W-1:0] alu_eval(input logic op,
                                                input logic [ALU_W-1:0] a,
                                                input logic [ALU_W-1:0] b);
    return (op == OP_AND) ? (a & b) : (a ^ b);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves away from the winner.
module rr_arb2 #(
  parameter int RST_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio_q;
  logic prio_d;

  // Grant selection and next pointer value.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    gnt    = req;
    prio_d = prio_q;
    if (req == 2'b11) begin
      gnt = prio_q ? 2'b10 : 2'b01;
    end
    if (gnt[0]) begin
      prio_d = 1'b1;
    end else if (gnt[1]) begin
      prio_d = 1'b0;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (rst) begin
      prio_q <= 1'(RST_PRIO);
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/tiny_alu.sv
// 4-bit XOR/AND ALU: operands registered at E0, result registered at E1 using the op present at E1.
module tiny_alu
  import tiny_alu_pkg::*;
(
  input  logic             clk,
  input  logic             op,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  output logic [ALU_W-1:0] y
);

  logic [ALU_W-1:0] a_q, a_d;
  logic [ALU_W-1:0] b_q, b_d;
  logic [ALU_W-1:0] y_q, y_d;

  // Next-state values for the operand and result registers.
  always_comb begin
    a_d = a;
    b_d = b;
    y_d = alu_eval(op, a_q, b_q);
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: pure datapath with no reset; consumers qualify y with their own cleared valid bits.
    a_q <= a_d;
    b_q <= b_d;
    y_q <= y_d;
  end

  assign y = y_q;

endmodule

// File: rtl/tiny_alu_sched.sv
// Round-robin scheduler sharing one tiny_alu between two requesters; results return 2 cycles after accept.
module tiny_alu_sched
  import tiny_alu_pkg::*;
#(
  parameter int RST_PRIO = 0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic [ALU_W-1:0] req0_a,
  input  logic [ALU_W-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic [ALU_W-1:0] req1_a,
  input  logic [ALU_W-1:0] req1_b,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [ALU_W-1:0] rsp_data,
  output logic [CNT_W-1:0] issue_cnt
);

  logic [1:0]       req;
  logic [1:0]       gnt;
  logic [ALU_W-1:0] alu_a;
  logic [ALU_W-1:0] alu_b;
  logic [ALU_W-1:0] alu_y;
  s1_t              s1_q, s1_d;
  s2_t              s2_q, s2_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;

  // Requests are masked while reset is asserted so no ready is raised.
  assign req = {req1_valid, req0_valid} & {2{~rst}};

  rr_arb2 #(
    .RST_PRIO (RST_PRIO)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  // Operand mux into the ALU and next values of the pipeline sideband and counter.
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    s1_d        = '0;
    issue_cnt_d = issue_cnt_q;
    if (gnt[0]) begin
      alu_a = req0_a;
      alu_b = req0_b;
      s1_d  = '{valid: 1'b1, id: REQ_ID_0, op: req0_op};
    end else if (gnt[1]) begin
      alu_a = req1_a;
      alu_b = req1_b;
      s1_d  = '{valid: 1'b1, id: REQ_ID_1, op: req1_op};
    end
    if (|gnt) begin
      issue_cnt_d = issue_cnt_q + CNT_W'(1);
    end
    s2_d = '{valid: s1_q.valid, id: s1_q.id};
  end

  // The ALU latches op at the same edge the stage-1 sideband advances, so it takes the registered op.
  tiny_alu u_alu (
    .clk (clk),
    .op  (s1_q.op),
    .a   (alu_a),
    .b   (alu_b),
    .y   (alu_y)
  );

  // Pipeline sideband and issue counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      issue_cnt_q <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign rsp0_valid = s2_q.valid && (s2_q.id == REQ_ID_0);
  assign rsp1_valid = s2_q.valid && (s2_q.id == REQ_ID_1);
  assign rsp_data   = s2_q.valid ? alu_y : '0;
  assign issue_cnt  = issue_cnt_q;

endmodule

// File: tb/tb_tiny_alu_sched.sv
// Scoreboard bench for tiny_alu_sched: driver predicts grants and results, monitor matches responses.
module tb_tiny_alu_sched;

  localparam int RST_PRIO = 0;
  localparam int CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0, req0_op = 1'b0;
  logic [3:0]       req0_a = '0, req0_b = '0;
  logic             req1_valid = 1'b0, req1_op = 1'b0;
  logic [3:0]       req1_a = '0, req1_b = '0;
  logic             req0_ready, req1_ready;
  logic             rsp0_valid, rsp1_valid;
  logic [3:0]       rsp_data;
  logic [CNT_W-1:0] issue_cnt;

  tiny_alu_sched #(
    .RST_PRIO (RST_PRIO),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_data   (rsp_data),
    .issue_cnt  (issue_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         id;
    logic [3:0] data;
    int         due;
  } exp_t;

  typedef struct {
    logic       v;
    logic       op;
    logic [3:0] a;
    logic [3:0] b;
  } req_t;

  exp_t             sb[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  int               m_prio = RST_PRIO;
  logic [CNT_W-1:0] m_cnt = '0;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [3:0] ref_alu(input logic op, input logic [3:0] a, input logic [3:0] b);
    return op ? (a & b) : (a ^ b);
  endfunction

  // One cycle of stimulus: drive, predict the grant, compare ready, log the expected result.
  task automatic step(input req_t r0, input req_t r1, output int g);
    @(negedge clk);
    req0_valid = r0.v; req0_op = r0.op; req0_a = r0.a; req0_b = r0.b;
    req1_valid = r1.v; req1_op = r1.op; req1_a = r1.a; req1_b = r1.b;
    #1;
    if (r0.v && r1.v) g = m_prio;
    else if (r0.v)    g = 0;
    else if (r1.v)    g = 1;
    else              g = -1;
    check("req0_ready", int'(req0_ready), int'(g == 0));
    check("req1_ready", int'(req1_ready), int'(g == 1));
    check("issue_cnt", int'(issue_cnt), int'(m_cnt));
    if (g >= 0) begin
      exp_t e;
      e.id   = g;
      e.data = (g == 0) ? ref_alu(r0.op, r0.a, r0.b) : ref_alu(r1.op, r1.a, r1.b);
      e.due  = cyc + 2;
      sb.push_back(e);
      m_cnt  = m_cnt + 1'b1;
      m_prio = 1 - g;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    sb.delete();
    m_cnt  = '0;
    m_prio = RST_PRIO;
    #1;
    check("rst_ready0", int'(req0_ready), 0);
    check("rst_ready1", int'(req1_ready), 0);
    check("rst_rsp_valid", int'({rsp0_valid, rsp1_valid}), 0);
    check("rst_rsp_data", int'(rsp_data), 0);
    check("rst_issue_cnt", int'(issue_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: matches each response pulse against the oldest expected entry.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (rsp0_valid || rsp1_valid) begin
        check("rsp_onehot", int'(rsp0_valid && rsp1_valid), 0);
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_unexpected: got pulse rsp0=%0b rsp1=%0b data=%h, required none (cycle %0d)",
                   rsp0_valid, rsp1_valid, rsp_data, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_id", rsp1_valid ? 1 : 0, e.id);
          check("rsp_data", int'(rsp_data), int'(e.data));
          check("rsp_cycle", cyc, e.due);
        end
      end else begin
        check("rsp_data_idle", int'(rsp_data), 0);
        if (sb.size() != 0 && sb[0].due <= cyc) begin
          exp_t e;
          e = sb.pop_front();
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_missing: got no pulse, required id=%0d data=%h at cycle %0d", e.id, e.data, e.due);
        end
      end
    end
  end

  req_t idle  = '{v: 1'b0, op: 1'b0, a: 4'h0, b: 4'h0};
  req_t p0, p1;
  int   g;

  initial begin
    apply_reset();

    // Single requester XOR, then AND on requester 1.
    step('{v: 1'b1, op: 1'b0, a: 4'hA, b: 4'h6}, idle, g);
    step(idle, idle, g);
    step(idle, '{v: 1'b1, op: 1'b1, a: 4'hC, b: 4'hA}, g);
    step(idle, idle, g);
    step(idle, idle, g);

    // Contention: both held valid until accepted, then both reissued.
    p0 = '{v: 1'b1, op: 1'b0, a: 4'hF, b: 4'h0};
    p1 = '{v: 1'b1, op: 1'b1, a: 4'hF, b: 4'h3};
    for (int i = 0; i < 6; i++) begin
      step(p0, p1, g);
    end
    step(idle, idle, g);
    step(idle, idle, g);

    // Op re-timing: back-to-back XOR then AND on the same operands.
    step('{v: 1'b1, op: 1'b0, a: 4'h5, b: 4'h3}, idle, g);
    step('{v: 1'b1, op: 1'b1, a: 4'h5, b: 4'h3}, idle, g);
    step(idle, idle, g);
    step(idle, idle, g);
    step(idle, idle, g);

    // Reset mid-flight: accept with req1 holding priority, then reset; priority returns to RST_PRIO.
    step('{v: 1'b1, op: 1'b0, a: 4'h9, b: 4'h2}, idle, g);
    apply_reset();
    step('{v: 1'b1, op: 1'b0, a: 4'h1, b: 4'h2}, '{v: 1'b1, op: 1'b1, a: 4'h7, b: 4'h7}, g);
    check("prio_after_reset", g, RST_PRIO);
    step(idle, idle, g);
    step(idle, idle, g);
    step(idle, idle, g);

    // Randomized traffic with persistent requests.
    p0 = idle;
    p1 = idle;
    for (int i = 0; i < 400; i++) begin
      if (!p0.v && ($urandom % 4 != 0)) p0 = '{v: 1'b1, op: 1'($urandom), a: 4'($urandom), b: 4'($urandom)};
      if (!p1.v && ($urandom % 3 != 0)) p1 = '{v: 1'b1, op: 1'($urandom), a: 4'($urandom), b: 4'($urandom)};
      step(p0, p1, g);
      if (g == 0) p0.v = 1'b0;
      if (g == 1) p1.v = 1'b0;
    end
    step(idle, idle, g);
    step(idle, idle, g);
    step(idle, idle, g);

    // Counter wrap: 256 accepts from reset return issue_cnt to zero.
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      step('{v: 1'b1, op: 1'($urandom), a: 4'($urandom), b: 4'($urandom)}, idle, g);
    end
    step(idle, idle, g);
    check("issue_cnt_wrap", int'(issue_cnt), 0);
    step(idle, idle, g);
    step(idle, idle, g);
    step(idle, idle, g);

    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
